// File: rtl/control_fsm_if.sv
// Instruction-fetch and datapath-control bundle between control_fsm and its memory/datapath.
// master = controller side, slave = memory/datapath side.
interface control_fsm_if;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic [4:0]  status_flags;
   logic        dp_enable;
   logic [15:0] reg_write_enable;
   logic [3:0]  reg_a_select;
   logic [3:0]  reg_b_select;
   logic        immediate_select;
   logic [15:0] immediate;
   logic [3:0]  opcode;

   modport master (
      output mem_addr, dp_enable, reg_write_enable, reg_a_select, reg_b_select,
             immediate_select, immediate, opcode,
      input  mem_data, status_flags
   );

   modport slave (
      input  mem_addr, dp_enable, reg_write_enable, reg_a_select, reg_b_select,
             immediate_select, immediate, opcode,
      output mem_data, status_flags
   );
endinterface

// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer for a 16-bit load/store-less ALU core with conditional branches.
// Decodes the latched instruction word into datapath controls and manages the PC.
//
// state   | meaning
// FETCH   | PC presented on mem_addr, memory access in flight
// DECODE  | instruction word valid, latched into IR; illegal ops go to HALT
// EXECUTE | datapath enabled for ALU ops, PC advanced or branched at end
// HALT    | illegal instruction seen; only reset leaves
module control_fsm #(
   parameter logic [15:0] P_RESET_PC = 16'h0000
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_enable,
   control_fsm_if.master   bus,
   output logic            o_halted
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_pc;
   logic [15:0] r_ir;

   logic [3:0]  w_op;
   logic [3:0]  w_rdest;
   logic [3:0]  w_opext;
   logic [3:0]  w_rsrc;
   logic [7:0]  w_imm8;
   logic [15:0] w_sext8;
   logic        w_alu;
   logic        w_cmp;
   logic        w_branch;
   logic        w_taken;
   logic        w_fetched_valid;
   logic        w_exec_active;
   logic        w_flag_c;
   logic        w_flag_f;
   logic        w_flag_z;
   logic        w_flag_n;
   logic        w_flag_l_unused;

   assign w_op    = r_ir[15:12];
   assign w_rdest = r_ir[11:8];
   assign w_opext = r_ir[7:4];
   assign w_rsrc  = r_ir[3:0];
   assign w_imm8  = r_ir[7:0];
   assign w_sext8 = {{8{w_imm8[7]}}, w_imm8};

   assign w_flag_c        = bus.status_flags[4];
   assign w_flag_l_unused = bus.status_flags[3];
   assign w_flag_f        = bus.status_flags[2];
   assign w_flag_z        = bus.status_flags[1];
   assign w_flag_n        = bus.status_flags[0];

   // Legality is judged on the incoming word so an illegal op never reaches EXECUTE.
   always_comb begin
      w_fetched_valid = 1'b0;
      case (bus.mem_data[15:12])
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101,
         4'b1001, 4'b1011, 4'b1100, 4'b1101, 4'b1111: w_fetched_valid = 1'b1;
         default:                                       w_fetched_valid = 1'b0;
      endcase
   end

   always_comb begin
      w_alu                = 1'b0;
      w_cmp                = 1'b0;
      w_branch             = 1'b0;
      bus.immediate_select = 1'b0;
      bus.opcode           = w_op;
      bus.immediate        = w_sext8;
      case (w_op)
         4'b0000: begin
            w_alu      = (r_ir != 16'h0000);
            w_cmp      = (w_opext == 4'b1011);
            bus.opcode = w_opext;
         end
         4'b0001, 4'b0010, 4'b0011: begin
            w_alu                = 1'b1;
            bus.immediate_select = 1'b1;
            bus.immediate        = {8'h00, w_imm8};
         end
         4'b0101, 4'b1001, 4'b1011, 4'b1101: begin
            w_alu                = 1'b1;
            w_cmp                = (w_op == 4'b1011);
            bus.immediate_select = 1'b1;
         end
         4'b1111: begin
            w_alu                = 1'b1;
            bus.immediate_select = 1'b1;
            bus.opcode           = 4'b1101;
            bus.immediate        = {w_imm8, 8'h00};
         end
         4'b1100: w_branch = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (w_rdest)
         4'b0000: w_taken = w_flag_z;
         4'b0001: w_taken = ~w_flag_z;
         4'b0010: w_taken = w_flag_c;
         4'b0011: w_taken = ~w_flag_c;
         4'b0110: w_taken = w_flag_n;
         4'b0111: w_taken = ~w_flag_n;
         4'b1000: w_taken = w_flag_f;
         4'b1001: w_taken = ~w_flag_f;
         4'b1100: w_taken = ~w_flag_n & ~w_flag_z;
         4'b1101: w_taken = w_flag_n | w_flag_z;
         4'b1110: w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
      w_taken = w_taken & w_branch;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_FETCH;
      end else if (i_enable) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH:   w_state_next = S_DECODE;
         S_DECODE:  w_state_next = w_fetched_valid ? S_EXECUTE : S_HALT;
         S_EXECUTE: w_state_next = S_FETCH;
         S_HALT:    w_state_next = S_HALT;
         default:   w_state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc <= P_RESET_PC;
         r_ir <= 16'h0000;
      end else if (i_enable) begin
         if (r_state == S_DECODE) begin
            r_ir <= bus.mem_data;
         end
         if (r_state == S_EXECUTE) begin
            r_pc <= w_taken ? (r_pc + w_sext8) : (r_pc + 16'h0001);
         end
      end
   end

   // Gating with reset keeps a mid-flight write from landing on the aborting edge.
   assign w_exec_active        = (r_state == S_EXECUTE) & i_enable & ~i_reset;
   assign bus.dp_enable        = w_exec_active & w_alu;
   assign bus.reg_write_enable = (bus.dp_enable & ~w_cmp) ? (16'h0001 << w_rdest) : 16'h0000;
   assign bus.reg_a_select     = w_rsrc;
   assign bus.reg_b_select     = w_rdest;
   assign bus.mem_addr         = r_pc;
   assign o_halted             = (r_state == S_HALT);

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: reset, immediate decode, write-back, branches,
// PC wrap, halt behaviour and run-enable stalls.
module tb_control_fsm;
   logic clk;
   logic i_reset;
   logic i_enable;
   logic o_halted;
   int   checks;
   int   errors;

   logic [15:0] mem [0:65535];

   control_fsm_if bus_if ();

   control_fsm #(.P_RESET_PC(16'h0000)) dut (
      .i_clk    (clk),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .bus      (bus_if.master),
      .o_halted (o_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction memory: word is valid one cycle after the address.
   always @(posedge clk) bus_if.mem_data <= mem[bus_if.mem_addr];

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
   endtask

   // Advances one whole instruction (FETCH -> DECODE -> EXECUTE -> next FETCH).
   task automatic run_instr();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      i_enable = 1'b0;
      i_reset  = 1'b1;
      bus_if.status_flags = 5'b00000;
      repeat (2) @(negedge clk);
      i_reset = 1'b0;
      checks++;
      if (bus_if.mem_addr !== 16'h0000) begin
         errors++; $display("FAIL reset_pc got %h exp %h", bus_if.mem_addr, 16'h0000);
      end
      checks++;
      if (o_halted !== 1'b0) begin
         errors++; $display("FAIL reset_halted got %b exp 0", o_halted);
      end
      checks++;
      if (bus_if.dp_enable !== 1'b0 || bus_if.reg_write_enable !== 16'h0000) begin
         errors++; $display("FAIL reset_enables got dp=%b we=%h exp dp=0 we=0000",
                            bus_if.dp_enable, bus_if.reg_write_enable);
      end
      i_enable = 1'b1;
   endtask

   task automatic test_addi();
      clear_mem();
      mem[0] = 16'h5305;
      do_reset();
      @(negedge clk);
      checks++;
      if (bus_if.dp_enable !== 1'b0) begin
         errors++; $display("FAIL addi_decode_dp got %b exp 0", bus_if.dp_enable);
      end
      @(negedge clk);
      checks++;
      if (bus_if.dp_enable !== 1'b1 || bus_if.reg_write_enable !== 16'h0008) begin
         errors++; $display("FAIL addi_exec_en got dp=%b we=%h exp dp=1 we=0008",
                            bus_if.dp_enable, bus_if.reg_write_enable);
      end
      checks++;
      if (bus_if.immediate !== 16'h0005 || bus_if.opcode !== 4'b0101 || bus_if.immediate_select !== 1'b1) begin
         errors++; $display("FAIL addi_exec_ctl got imm=%h op=%h isel=%b exp imm=0005 op=5 isel=1",
                            bus_if.immediate, bus_if.opcode, bus_if.immediate_select);
      end
      checks++;
      if (bus_if.reg_a_select !== 4'h5 || bus_if.reg_b_select !== 4'h3) begin
         errors++; $display("FAIL addi_sel got a=%h b=%h exp a=5 b=3",
                            bus_if.reg_a_select, bus_if.reg_b_select);
      end
      @(negedge clk);
      checks++;
      if (bus_if.mem_addr !== 16'h0001 || bus_if.dp_enable !== 1'b0) begin
         errors++; $display("FAIL addi_next_fetch got addr=%h dp=%b exp addr=0001 dp=0",
                            bus_if.mem_addr, bus_if.dp_enable);
      end
   endtask

   task automatic test_decode_table();
      logic [15:0] words   [8];
      logic        exp_dp  [8];
      logic [15:0] exp_we  [8];
      logic        exp_isel[8];
      logic [15:0] exp_imm [8];
      logic [3:0]  exp_opc [8];
      words = '{16'h52FF, 16'h12FF, 16'hF1AB, 16'h01B2, 16'hB305, 16'h0352, 16'hD380, 16'h0000};
      exp_dp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_we   = '{16'h0004, 16'h0004, 16'h0002, 16'h0000, 16'h0000, 16'h0008, 16'h0008, 16'h0000};
      exp_isel = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_imm  = '{16'hFFFF, 16'h00FF, 16'hAB00, 16'h0000, 16'h0005, 16'h0000, 16'hFF80, 16'h0000};
      exp_opc  = '{4'h5, 4'h1, 4'hD, 4'hB, 4'hB, 4'h5, 4'hD, 4'h0};
      clear_mem();
      for (int i = 0; i < 8; i++) mem[i] = words[i];
      do_reset();
      for (int i = 0; i < 8; i++) begin
         repeat (2) @(negedge clk);
         checks++;
         if (bus_if.dp_enable !== exp_dp[i] || bus_if.reg_write_enable !== exp_we[i]) begin
            errors++; $display("FAIL dec_en[%0d] got dp=%b we=%h exp dp=%b we=%h", i,
                               bus_if.dp_enable, bus_if.reg_write_enable, exp_dp[i], exp_we[i]);
         end
         if (exp_dp[i]) begin
            checks++;
            if (bus_if.opcode !== exp_opc[i] || bus_if.immediate_select !== exp_isel[i]) begin
               errors++; $display("FAIL dec_op[%0d] got op=%h isel=%b exp op=%h isel=%b", i,
                                  bus_if.opcode, bus_if.immediate_select, exp_opc[i], exp_isel[i]);
            end
         end
         if (exp_isel[i]) begin
            checks++;
            if (bus_if.immediate !== exp_imm[i]) begin
               errors++; $display("FAIL dec_imm[%0d] got %h exp %h", i, bus_if.immediate, exp_imm[i]);
            end
         end
         @(negedge clk);
         checks++;
         if (bus_if.mem_addr !== 16'(i + 1)) begin
            errors++; $display("FAIL dec_pc[%0d] got %h exp %h", i, bus_if.mem_addr, 16'(i + 1));
         end
      end
   endtask

   task automatic test_branch();
      logic [15:0] exp_run1 [3];
      logic [15:0] exp_run2 [4];
      exp_run1 = '{16'h0010, 16'h000C, 16'h000D};
      exp_run2 = '{16'h0010, 16'h0011, 16'h0013, 16'h0014};
      clear_mem();
      mem[16'h0000] = 16'hCE10;
      mem[16'h0010] = 16'hC0FC;
      mem[16'h000C] = 16'hCC02;
      mem[16'h0011] = 16'hCC02;
      mem[16'h0013] = 16'hC402;
      bus_if.status_flags = 5'b00010;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         repeat (2) @(negedge clk);
         checks++;
         if (bus_if.dp_enable !== 1'b0 || bus_if.reg_write_enable !== 16'h0000) begin
            errors++; $display("FAIL br1_en[%0d] got dp=%b we=%h exp dp=0 we=0000", i,
                               bus_if.dp_enable, bus_if.reg_write_enable);
         end
         @(negedge clk);
         checks++;
         if (bus_if.mem_addr !== exp_run1[i]) begin
            errors++; $display("FAIL br1_pc[%0d] got %h exp %h", i, bus_if.mem_addr, exp_run1[i]);
         end
      end
      bus_if.status_flags = 5'b00000;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_instr();
         checks++;
         if (bus_if.mem_addr !== exp_run2[i]) begin
            errors++; $display("FAIL br2_pc[%0d] got %h exp %h", i, bus_if.mem_addr, exp_run2[i]);
         end
      end
   endtask

   task automatic test_pc_wrap();
      clear_mem();
      mem[16'h0000] = 16'hCEFF;
      mem[16'hFFFF] = 16'h5305;
      do_reset();
      run_instr();
      checks++;
      if (bus_if.mem_addr !== 16'hFFFF) begin
         errors++; $display("FAIL wrap_back got %h exp FFFF", bus_if.mem_addr);
      end
      run_instr();
      checks++;
      if (bus_if.mem_addr !== 16'h0000) begin
         errors++; $display("FAIL wrap_fwd got %h exp 0000", bus_if.mem_addr);
      end
   endtask

   task automatic test_halt();
      clear_mem();
      mem[1] = 16'h7000;
      do_reset();
      run_instr();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (o_halted !== 1'b1 || bus_if.mem_addr !== 16'h0001 || bus_if.dp_enable !== 1'b0) begin
            errors++; $display("FAIL halt_hold[%0d] got h=%b addr=%h dp=%b exp h=1 addr=0001 dp=0", i,
                               o_halted, bus_if.mem_addr, bus_if.dp_enable);
         end
         @(negedge clk);
      end
      do_reset();
      checks++;
      if (o_halted !== 1'b0 || bus_if.mem_addr !== 16'h0000) begin
         errors++; $display("FAIL halt_exit got h=%b addr=%h exp h=0 addr=0000", o_halted, bus_if.mem_addr);
      end
      run_instr();
      checks++;
      if (bus_if.mem_addr !== 16'h0001) begin
         errors++; $display("FAIL halt_rerun got %h exp 0001", bus_if.mem_addr);
      end
   endtask

   task automatic test_enable_stall();
      clear_mem();
      mem[0] = 16'h5305;
      do_reset();
      repeat (2) @(negedge clk);
      i_enable = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus_if.dp_enable !== 1'b0 || bus_if.reg_write_enable !== 16'h0000 || bus_if.mem_addr !== 16'h0000) begin
            errors++; $display("FAIL stall[%0d] got dp=%b we=%h addr=%h exp dp=0 we=0000 addr=0000", i,
                               bus_if.dp_enable, bus_if.reg_write_enable, bus_if.mem_addr);
         end
         @(negedge clk);
      end
      i_enable = 1'b1;
      #1;
      checks++;
      if (bus_if.dp_enable !== 1'b1 || bus_if.reg_write_enable !== 16'h0008) begin
         errors++; $display("FAIL stall_resume got dp=%b we=%h exp dp=1 we=0008",
                            bus_if.dp_enable, bus_if.reg_write_enable);
      end
      @(negedge clk);
      checks++;
      if (bus_if.mem_addr !== 16'h0001 || bus_if.dp_enable !== 1'b0) begin
         errors++; $display("FAIL stall_once got addr=%h dp=%b exp addr=0001 dp=0",
                            bus_if.mem_addr, bus_if.dp_enable);
      end
      run_instr();
      checks++;
      if (bus_if.mem_addr !== 16'h0002) begin
         errors++; $display("FAIL stall_after got %h exp 0002", bus_if.mem_addr);
      end
   endtask

   task automatic test_reset_abort();
      clear_mem();
      mem[0] = 16'h5305;
      do_reset();
      repeat (2) @(negedge clk);
      i_reset = 1'b1;
      #1;
      checks++;
      if (bus_if.dp_enable !== 1'b0 || bus_if.reg_write_enable !== 16'h0000) begin
         errors++; $display("FAIL abort_en got dp=%b we=%h exp dp=0 we=0000",
                            bus_if.dp_enable, bus_if.reg_write_enable);
      end
      @(negedge clk);
      i_reset = 1'b0;
      checks++;
      if (bus_if.mem_addr !== 16'h0000 || o_halted !== 1'b0) begin
         errors++; $display("FAIL abort_state got addr=%h h=%b exp addr=0000 h=0", bus_if.mem_addr, o_halted);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus_if.reg_write_enable !== 16'h0008) begin
         errors++; $display("FAIL abort_rerun got we=%h exp 0008", bus_if.reg_write_enable);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      i_reset  = 1'b1;
      i_enable = 1'b0;
      bus_if.status_flags = 5'b00000;
      clear_mem();
      test_reset();
      test_addi();
      test_decode_table();
      test_branch();
      test_pc_wrap();
      test_halt();
      test_enable_stall();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
